// File: rtl/tl_pkg.sv
// Shared phase encoding for the intersection sequencer and the lamp decoder.
// Phase = {approach[1:0], yellow}; approach 0..3 maps to sensors a..d.
package tl_pkg;

    localparam int unsigned IDX_W = 2;

    typedef enum logic [2:0] {
        S1G = 3'b000,
        S1Y = 3'b001,
        S2G = 3'b010,
        S2Y = 3'b011,
        S3G = 3'b100,
        S3Y = 3'b101,
        S4G = 3'b110,
        S4Y = 3'b111
    } phase_t;

    function automatic phase_t make_phase(input logic [IDX_W-1:0] idx, input logic yellow);
        return phase_t'({idx, yellow});
    endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Round-robin picker: first demanding approach after cur (mod 4), cur itself excluded.
module tl_rr_pick
    import tl_pkg::*;
(
    input  logic [3:0]       demand,
    input  logic [IDX_W-1:0] cur,
    output logic [IDX_W-1:0] pick,
    output logic             any
);

    logic [IDX_W-1:0] idx;

    // Scan farthest-first so the nearest successor overwrites and wins.
    always_comb begin
        pick = cur;
        any  = 1'b0;
        idx  = '0;
        for (int unsigned k = 3; k >= 1; k--) begin
            idx = cur + IDX_W'(k);
            if (demand[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_phase_fsm.sv
// Sensor-actuated green/yellow round-robin sequencer for a four-approach intersection.
// Rests on green without contention; otherwise green dwell is GREEN_MIN..GREEN_MAX.
module tl_phase_fsm
    import tl_pkg::*;
#(
    parameter int unsigned GREEN_MIN = 4,
    parameter int unsigned GREEN_MAX = 10,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    output logic [2:0]       state,
    output logic [2:0]       next_state,
    output logic             phase_change,
    output logic [CNT_W-1:0] timer
);

    localparam logic [CNT_W-1:0] G_MIN_T = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] G_MAX_T = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] Y_T     = CNT_W'(YELLOW_T - 1);

    phase_t           cur_q, nxt;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [3:0]       demand_q, demand_d;
    logic [IDX_W-1:0] target_q;
    logic             pc_q;

    logic [3:0]       sensor;
    logic [IDX_W-1:0] cur_idx, pick;
    logic             is_yel, others, change;

    assign sensor  = {d, c, b, a};
    assign cur_idx = cur_q[2:1];
    assign is_yel  = cur_q[0];

    tl_rr_pick u_pick (
        .demand (demand_q),
        .cur    (cur_idx),
        .pick   (pick),
        .any    (others)
    );

    always_comb begin
        nxt = cur_q;
        if (!is_yel) begin
            if (others && (timer_q >= G_MAX_T || (timer_q >= G_MIN_T && !sensor[cur_idx])))
                nxt = make_phase(cur_idx, 1'b1);
        end else if (timer_q >= Y_T) begin
            nxt = make_phase(target_q, 1'b0);
        end
    end

    assign change = (nxt != cur_q);

    // Own-green masking drops sensor sets; entering green clears last so it wins.
    always_comb begin
        demand_d = demand_q | sensor;
        if (!is_yel)
            demand_d[cur_idx] = 1'b0;
        if (change && !nxt[0])
            demand_d[nxt[2:1]] = 1'b0;
    end

    always_comb begin
        timer_d = '0;
        if (!change)
            timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_q    <= S1G;
            timer_q  <= '0;
            demand_q <= '0;
            target_q <= '0;
            pc_q     <= 1'b0;
        end else begin
            cur_q    <= nxt;
            timer_q  <= timer_d;
            demand_q <= demand_d;
            pc_q     <= change;
            if (!is_yel && nxt[0])
                target_q <= pick;
        end
    end

    assign state        = cur_q;
    assign next_state   = nxt;
    assign phase_change = pc_q;
    assign timer        = timer_q;

endmodule

// File: tb/tb_tl_phase_fsm.sv
// Directed bench for tl_phase_fsm with GREEN_MIN=4, GREEN_MAX=10, YELLOW_T=2.
module tb_tl_phase_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic [2:0] state, next_state;
    logic       phase_change;
    logic [7:0] timer;

    int total = 0;
    int bad   = 0;

    tl_phase_fsm #(
        .GREEN_MIN (4),
        .GREEN_MAX (10),
        .YELLOW_T  (2),
        .CNT_W     (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a            (a),
        .b            (b),
        .c            (c),
        .d            (d),
        .state        (state),
        .next_state   (next_state),
        .phase_change (phase_change),
        .timer        (timer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input string tag, input int st, input int pc, input int tm);
        chk({tag, "_state"}, int'(state), st);
        chk({tag, "_pc"}, int'(phase_change), pc);
        chk({tag, "_timer"}, int'(timer), tm);
    endtask

    // Checks a full phase of n cycles entered with a phase_change pulse.
    task automatic dwell(input string tag, input int st, input int n);
        for (int i = 0; i < n; i++) begin
            expect_cyc(tag, st, (i == 0) ? 1 : 0, i);
            tick();
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        a = 1'b0; b = 1'b0; c = 1'b0; d = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        expect_cyc("rst", 0, 0, 0);
        chk("rst_next", int'(next_state), 0);
    endtask

    initial begin
        // 1: idle rest on S1G, timer saturates at 255
        do_reset(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            chk("idle_state", int'(state), 0);
            chk("idle_pc", int'(phase_change), 0);
            chk("idle_timer", int'(timer), (k > 255) ? 255 : k);
        end

        // 2: one-cycle pulse on c -> S1G 4, S1Y 2, S3G rests
        do_reset(1);
        rst_n = 1'b1;
        tick();
        expect_cyc("t2_g", 0, 0, 1);
        c = 1'b1;
        tick();
        c = 1'b0;
        expect_cyc("t2_g", 0, 0, 2);
        tick();
        expect_cyc("t2_g", 0, 0, 3);
        chk("t2_next", int'(next_state), 1);
        tick();
        dwell("t2_s1y", 1, 2);
        dwell("t2_s3g", 4, 20);

        // 3: a and b held -> 10/2/10/2 alternation
        do_reset(1);
        rst_n = 1'b1;
        a = 1'b1; b = 1'b1;
        tick();
        for (int i = 1; i < 10; i++) begin
            expect_cyc("t3_s1g0", 0, 0, i);
            tick();
        end
        dwell("t3_s1y", 1, 2);
        dwell("t3_s2g", 2, 10);
        dwell("t3_s2y", 3, 2);
        dwell("t3_s1g", 0, 10);
        dwell("t3_s1y", 1, 2);
        dwell("t3_s2g", 2, 10);

        // 6: reset mid-S2Y aborts yellow and clears pending demand
        expect_cyc("t6_s2y", 3, 1, 0);
        rst_n = 1'b0;
        a = 1'b0; b = 1'b0;
        tick();
        expect_cyc("t6_rst", 0, 0, 0);
        chk("t6_next", int'(next_state), 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            expect_cyc("t6_rest", 0, 0, k);
        end

        // 4: from S4G with a and c pending, wrap picks a
        do_reset(1);
        rst_n = 1'b1;
        d = 1'b1;
        tick();
        d = 1'b0;
        expect_cyc("t4_g", 0, 0, 1);
        tick();
        tick();
        expect_cyc("t4_g", 0, 0, 3);
        tick();
        dwell("t4_s1y", 1, 2);
        expect_cyc("t4_s4g", 6, 1, 0);
        a = 1'b1; c = 1'b1;
        tick();
        a = 1'b0; c = 1'b0;
        expect_cyc("t4_s4g", 6, 0, 1);
        tick();
        tick();
        expect_cyc("t4_s4g", 6, 0, 3);
        chk("t4_next", int'(next_state), 7);
        tick();
        dwell("t4_s4y", 7, 2);
        expect_cyc("t4_s1g", 0, 1, 0);

        // 5: b raised during S1Y targeting c -> S3G first, then S2G
        do_reset(1);
        rst_n = 1'b1;
        c = 1'b1;
        tick();
        c = 1'b0;
        tick();
        tick();
        expect_cyc("t5_g", 0, 0, 3);
        tick();
        expect_cyc("t5_s1y", 1, 1, 0);
        b = 1'b1;
        tick();
        b = 1'b0;
        expect_cyc("t5_s1y", 1, 0, 1);
        tick();
        dwell("t5_s3g", 4, 4);
        dwell("t5_s3y", 5, 2);
        expect_cyc("t5_s2g", 2, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
